mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of EX. Latches EX results (EX/MEM register), runs load/store bus
//  transactions with a req/ack handshake, aligns and sign-extends load data, forwards results to WB.
//  Raises stallreq_o to ctrl while a bus access is outstanding; non-memory ops pass through in 1 cycle.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles in REQ with no ack before abort (>=2)
//  CNT_W           5   timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   async active-high reset
//  ex_valid_i     in   1   EX presents an instruction this cycle
//  ex_wd_i        in   5   dest reg addr
//  ex_wreg_i      in   1   dest write enable
//  ex_wdata_i     in   32  EX result (ALU/link value)
//  ex_aluop_i     in   8   op code; LB/LH/LW/LBU/LHU/SB/SH/SW select memory ops
//  ex_mem_addr_i  in   32  effective address
//  ex_mem_data_i  in   32  store data (rs2)
//  flush_i        in   1   discard the EX op offered this cycle
//  mem_req_o      out  1   bus request, held until ack
//  mem_we_o       out  1   1=store
//  mem_addr_o     out  32  word-aligned address {addr[31:2],2'b00}
//  mem_be_o       out  4   byte enables
//  mem_wdata_o    out  32  store data replicated into lanes
//  mem_ack_i      in   1   one-cycle completion strobe
//  mem_rdata_i    in   32  read word, valid with ack
//  wb_valid_o     out  1   result valid for WB
//  wb_wd_o        out  5   dest reg addr
//  wb_wreg_o      out  1   dest write enable
//  wb_wdata_o     out  32  result data
//  stallreq_o     out  1   hold IF..EX
//  bus_err_o      out  1   one-cycle pulse on timeout (or misalign, see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, counter=0, every output 0 (mem_req_o drops mid-transaction).
//  FSM: IDLE -> REQ on capture of a memory op; REQ -> IDLE on ack or timeout.
//  Capture: in IDLE with ex_valid_i & !flush_i & !stallreq_o, latch all ex_* fields.
//  Non-memory op: wb_* = latched fields next cycle (latency 1); wb_valid_o pulses 1 cycle.
//  Memory op: mem_req_o/we/addr/be/wdata registered, asserted cycle after capture, stable until ack.
//  stallreq_o = (state==REQ) & !mem_ack_i (combinational); ex_* inputs ignored while in REQ.
//  Ack in REQ: next cycle wb_valid_o=1; load -> wb_wdata_o = aligned rdata, store -> wb_wreg_o=0.
//  Best-case load: capture N, req N+1 (ack N+1), wb_valid N+2. Ack outside REQ ignored.
//  Byte lane = addr[1:0]; half lane = addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
//  SB: be=4'b0001<<addr[1:0], data {4{d[7:0]}}; SH: be=addr[1]?1100:0011, data {2{d[15:0]}}; SW: be=1111.
//  Counter clears on entry to REQ, +1 per REQ cycle; at TIMEOUT_CYCLES without ack: drop req, bus_err_o
//  pulse, wb_valid_o=1 with wb_wreg_o=0, return IDLE. Ack on the timeout cycle wins (normal completion).
//  flush_i only blocks capture that cycle; an op already in REQ completes (older than the flushing branch).
//  Capture concurrent with completion impossible: stallreq_o holds EX until IDLE.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 issue no bus
//   request; next cycle bus_err_o pulses, wb_valid_o=1, wb_wreg_o=0, state stays IDLE.
//  Undefined: low address bits beyond access size ignored (LW at ...2 reads word at ...0; SH at ...1 uses
//   lanes 0-1); bus_err_o only on timeout.
// STRUCTURE
//  defines.v: load/store AluOp codes, MEM_IDLE/MEM_REQ state encodings, byte-enable constants.
//  Sub-module mem_ldst_align (combinational): aluop+addr[1:0]+data -> be, store lanes, load extension.
// TESTING
//  LW addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF -> wb_wdata 0xDEADBEEF, wb_valid at N+2.
//  LB addr 0x103, rdata 0x80xxxxxx -> 0xFFFFFF80; LBU same -> 0x00000080; LH 0x102 rdata 0x8001xxxx -> 0xFFFF8001.
//  SB addr 0x101 data 0x12345678 -> be 0010, wdata 0x78787878, wb_wreg 0; SH 0x102 -> be 1100, 0x56785678.
//  No ack 16 cycles -> stallreq high 16 cycles, bus_err pulse, wb_valid with wreg 0, req low after.
//  rst pulse mid-REQ -> mem_req_o, stallreq_o, wb_valid_o 0 immediately; ADD after reset passes in 1 cycle.
//  flush_i with LW offered -> no req; with MEM_MISALIGN_TRAP_EN, LW 0x102 -> no req, bus_err pulse.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage_pkg : op codes, FSM encodings and byte-enable constants for MEM.
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam logic [7:0] OP_ADD = 8'b0010_0000;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  localparam logic [0:0] MEM_IDLE = 1'b0;
  localparam logic [0:0] MEM_REQ  = 1'b1;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
    return (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && lo[0]) ||
           (((op == OP_LW) || (op == OP_SW)) && (lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ldst_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_ldst_align : byte enables, store lane replication and load extension.
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_ldst_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      2'd3:    w_byte = rdata_i[31:24];
      default: w_byte = rdata_i[7:0];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o    = BE_NONE;
    wdata_o = st_data_i;
    ldata_o = rdata_i;
    case (aluop_i)
      OP_LB, OP_LBU, OP_SB: begin
        be_o    = BE_BYTE0 << addr_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
        ldata_o = (aluop_i == OP_LB) ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
      end
      OP_LH, OP_LHU, OP_SH: begin
        be_o    = addr_lo_i[1] ? BE_HI_HALF : BE_LO_HALF;
        wdata_o = {2{st_data_i[15:0]}};
        ldata_o = (aluop_i == OP_LH) ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
      end
      OP_LW, OP_SW: be_o = BE_WORD;
      default: be_o = BE_NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage : EX/MEM register, req/ack bus FSM with timeout, result to WB.
// Optional: MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [7:0]  ex_aluop_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_mem_data_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic        stallreq_o,
  output logic        bus_err_o
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d, we_q, we_d;
  logic [31:0]      addr_q, addr_d, mwdata_q, mwdata_d;
  logic [3:0]       be_q, be_d;
  logic             wbv_q, wbv_d, wbwreg_q, wbwreg_d, err_q, err_d;
  logic [4:0]       wbwd_q, wbwd_d, wd_q, wd_d;
  logic [31:0]      wbdata_q, wbdata_d, exdata_q, exdata_d;
  logic             wreg_q, wreg_d;
  logic [7:0]       op_q, op_d;
  logic [1:0]       lo_q, lo_d;

  logic        w_capture, w_is_mem, w_trap, w_timeout;
  logic [7:0]  w_al_op;
  logic [1:0]  w_al_lo;
  logic [3:0]  w_be;
  logic [31:0] w_st, w_ld;

  assign stallreq_o = (state_q == MEM_REQ) && !mem_ack_i;
  assign w_capture  = (state_q == MEM_IDLE) && ex_valid_i && !flush_i && !stallreq_o;
  assign w_is_mem   = is_load(ex_aluop_i) || is_store(ex_aluop_i);
  assign w_timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap     = is_misaligned(ex_aluop_i, ex_mem_addr_i[1:0]);
`else
  assign w_trap     = 1'b0;
`endif

  // Shared aligner: EX fields drive store lanes in IDLE, latched op drives load extension in REQ.
  assign w_al_op = (state_q == MEM_REQ) ? op_q : ex_aluop_i;
  assign w_al_lo = (state_q == MEM_REQ) ? lo_q : ex_mem_addr_i[1:0];

  mem_ldst_align u_align (
    .aluop_i   (w_al_op),
    .addr_lo_i (w_al_lo),
    .st_data_i (ex_mem_data_i),
    .rdata_i   (mem_rdata_i),
    .be_o      (w_be),
    .wdata_o   (w_st),
    .ldata_o   (w_ld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MEM_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (w_capture && w_is_mem && !w_trap) state_d = MEM_REQ;
      MEM_REQ:  if (mem_ack_i || w_timeout) state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;    req_d    = req_q;    we_d     = we_q;
    addr_d   = addr_q;   be_d     = be_q;     mwdata_d = mwdata_q;
    wbv_d    = 1'b0;     err_d    = 1'b0;
    wbwd_d   = wbwd_q;   wbwreg_d = wbwreg_q; wbdata_d = wbdata_q;
    wd_d     = wd_q;     wreg_d   = wreg_q;   exdata_d = exdata_q;
    op_d     = op_q;     lo_d     = lo_q;
    if (state_q == MEM_IDLE) begin
      if (w_capture) begin
        wbwd_d = ex_wd_i;
        if (!w_is_mem) begin
          wbv_d    = 1'b1;
          wbwreg_d = ex_wreg_i;
          wbdata_d = ex_wdata_i;
        end else if (w_trap) begin
          wbv_d    = 1'b1;
          wbwreg_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          req_d    = 1'b1;
          we_d     = is_store(ex_aluop_i);
          addr_d   = {ex_mem_addr_i[31:2], 2'b00};
          be_d     = w_be;
          mwdata_d = w_st;
          cnt_d    = '0;
          wd_d     = ex_wd_i;
          wreg_d   = ex_wreg_i;
          exdata_d = ex_wdata_i;
          op_d     = ex_aluop_i;
          lo_d     = ex_mem_addr_i[1:0];
        end
      end
    end else if (mem_ack_i) begin
      req_d    = 1'b0;
      we_d     = 1'b0;
      wbv_d    = 1'b1;
      wbwd_d   = wd_q;
      wbwreg_d = is_load(op_q) && wreg_q;
      wbdata_d = is_load(op_q) ? w_ld : exdata_q;
    end else if (w_timeout) begin
      req_d    = 1'b0;
      we_d     = 1'b0;
      wbv_d    = 1'b1;
      wbwd_d   = wd_q;
      wbwreg_d = 1'b0;
      err_d    = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;  req_q <= 1'b0;  we_q <= 1'b0;  addr_q <= '0;  be_q <= '0;
      mwdata_q <= '0;  wbv_q <= 1'b0;  err_q <= 1'b0;  wbwd_q <= '0;
      wbwreg_q <= 1'b0;  wbdata_q <= '0;  wd_q <= '0;  wreg_q <= 1'b0;
      exdata_q <= '0;  op_q <= '0;  lo_q <= '0;
    end else begin
      cnt_q <= cnt_d;  req_q <= req_d;  we_q <= we_d;  addr_q <= addr_d;  be_q <= be_d;
      mwdata_q <= mwdata_d;  wbv_q <= wbv_d;  err_q <= err_d;  wbwd_q <= wbwd_d;
      wbwreg_q <= wbwreg_d;  wbdata_q <= wbdata_d;  wd_q <= wd_d;  wreg_q <= wreg_d;
      exdata_q <= exdata_d;  op_q <= op_d;  lo_q <= lo_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = mwdata_q;
  assign wb_valid_o  = wbv_q;
  assign wb_wd_o     = wbwd_q;
  assign wb_wreg_o   = wbwreg_q;
  assign wb_wdata_o  = wbdata_q;
  assign bus_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_stage : directed self-checking bench for mem_stage.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_wreg_i, flush_i, mem_ack_i;
  logic [4:0]  ex_wd_i;
  logic [7:0]  ex_aluop_i;
  logic [31:0] ex_wdata_i, ex_mem_addr_i, ex_mem_data_i, mem_rdata_i;
  logic        mem_req_o, mem_we_o, wb_valid_o, wb_wreg_o, stallreq_o, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, wb_wdata_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  wb_wd_o;

  int n_pass  = 0;
  int n_total = 0;

  mem_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i),
    .ex_wdata_i(ex_wdata_i), .ex_aluop_i(ex_aluop_i), .ex_mem_addr_i(ex_mem_addr_i),
    .ex_mem_data_i(ex_mem_data_i), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o),
    .wb_wdata_o(wb_wdata_o), .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] wdata, input logic [4:0] wd);
    ex_valid_i = 1'b1; ex_aluop_i = op; ex_mem_addr_i = addr; ex_mem_data_i = sdata;
    ex_wdata_i = wdata; ex_wd_i = wd; ex_wreg_i = 1'b1;
    tick();
    ex_valid_i = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    issue(op, addr, 32'h0, 32'h0, 5'd3);
    check({tag, "_req"},   32'(mem_req_o), 32'd1);
    check({tag, "_we"},    32'(mem_we_o), 32'd0);
    check({tag, "_addr"},  mem_addr_o, waddr);
    check({tag, "_stall"}, 32'(stallreq_o), 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = rdata;
    #1;
    check({tag, "_stall_ack"}, 32'(stallreq_o), 32'd0);
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    check({tag, "_wbv"},   32'(wb_valid_o), 32'd1);
    check({tag, "_data"},  wb_wdata_o, exp);
    check({tag, "_wreg"},  32'(wb_wreg_o), 32'd1);
    check({tag, "_wd"},    32'(wb_wd_o), 32'd3);
    check({tag, "_reqlo"}, 32'(mem_req_o), 32'd0);
    tick();
    check({tag, "_wbv_pulse"}, 32'(wb_valid_o), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_data);
    issue(op, addr, sdata, 32'h0, 5'd4);
    check({tag, "_req"},  32'(mem_req_o), 32'd1);
    check({tag, "_we"},   32'(mem_we_o), 32'd1);
    check({tag, "_be"},   32'(mem_be_o), 32'(exp_be));
    check({tag, "_wdat"}, mem_wdata_o, exp_data);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check({tag, "_wbv"},  32'(wb_valid_o), 32'd1);
    check({tag, "_wreg"}, 32'(wb_wreg_o), 32'd0);
    tick();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; ex_valid_i = 1'b0; ex_wreg_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
    ex_wd_i = '0; ex_aluop_i = '0; ex_wdata_i = '0; ex_mem_addr_i = '0;
    ex_mem_data_i = '0; mem_rdata_i = '0;
    #12;
    check("rst_req",  32'(mem_req_o), 32'd0);
    check("rst_wbv",  32'(wb_valid_o), 32'd0);
    check("rst_stall", 32'(stallreq_o), 32'd0);
    check("rst_err",  32'(bus_err_o), 32'd0);
    check("rst_wdata", wb_wdata_o, 32'd0);
    rst = 1'b0;
    tick();

    do_load("lw",  OP_LW,  32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb",  OP_LB,  32'h103, 32'h80123456, 32'hFFFFFF80);
    do_load("lbu", OP_LBU, 32'h103, 32'h80123456, 32'h00000080);
    do_load("lh",  OP_LH,  32'h102, 32'h8001ABCD, 32'hFFFF8001);
    do_load("lhu", OP_LHU, 32'h100, 32'h1234F00D, 32'h0000F00D);
    do_store("sb", OP_SB, 32'h101, 32'h12345678, 4'b0010, 32'h78787878);
    do_store("sh", OP_SH, 32'h102, 32'h12345678, 4'b1100, 32'h56785678);
    do_store("sw", OP_SW, 32'h104, 32'h12345678, 4'b1111, 32'h12345678);

    // Timeout: no ack at all.
    issue(OP_LW, 32'h200, 32'h0, 32'h0, 5'd7);
    cnt = 0;
    while (stallreq_o && cnt < 40) begin
      cnt++;
      tick();
    end
    check("to_stall_cycles", 32'(cnt), 32'd16);
    check("to_err",   32'(bus_err_o), 32'd1);
    check("to_wbv",   32'(wb_valid_o), 32'd1);
    check("to_wreg",  32'(wb_wreg_o), 32'd0);
    check("to_reqlo", 32'(mem_req_o), 32'd0);
    tick();
    check("to_err_pulse", 32'(bus_err_o), 32'd0);
    check("to_wbv_pulse", 32'(wb_valid_o), 32'd0);

    // Ack on the timeout cycle completes normally.
    issue(OP_LW, 32'h300, 32'h0, 32'h0, 5'd8);
    repeat (15) tick();
    check("tack_still_req", 32'(mem_req_o), 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5_0F0F;
    tick();
    mem_ack_i = 1'b0;
    check("tack_err",  32'(bus_err_o), 32'd0);
    check("tack_wbv",  32'(wb_valid_o), 32'd1);
    check("tack_wreg", 32'(wb_wreg_o), 32'd1);
    check("tack_data", wb_wdata_o, 32'hA5A5_0F0F);
    tick();

    // Stray ack in IDLE.
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check("stray_wbv", 32'(wb_valid_o), 32'd0);
    check("stray_req", 32'(mem_req_o), 32'd0);

    // Reset mid-transaction, then an ALU op.
    issue(OP_LW, 32'h400, 32'h0, 32'h0, 5'd9);
    check("mr_req_before", 32'(mem_req_o), 32'd1);
    rst = 1'b1;
    #1;
    check("mr_req",   32'(mem_req_o), 32'd0);
    check("mr_stall", 32'(stallreq_o), 32'd0);
    check("mr_wbv",   32'(wb_valid_o), 32'd0);
    #1 rst = 1'b0;
    issue(OP_ADD, 32'h0, 32'h0, 32'h0000_0055, 5'd10);
    check("add_wbv",   32'(wb_valid_o), 32'd1);
    check("add_data",  wb_wdata_o, 32'h0000_0055);
    check("add_wreg",  32'(wb_wreg_o), 32'd1);
    check("add_wd",    32'(wb_wd_o), 32'd10);
    check("add_noreq", 32'(mem_req_o), 32'd0);
    tick();
    check("add_pulse", 32'(wb_valid_o), 32'd0);

    // Flushed load is dropped.
    flush_i = 1'b1;
    issue(OP_LW, 32'h500, 32'h0, 32'h0, 5'd11);
    flush_i = 1'b0;
    check("fl_req", 32'(mem_req_o), 32'd0);
    check("fl_wbv", 32'(wb_valid_o), 32'd0);
    tick();

`ifdef MEM_MISALIGN_TRAP_EN
    issue(OP_LW, 32'h102, 32'h0, 32'h0, 5'd12);
    check("ma_req",   32'(mem_req_o), 32'd0);
    check("ma_err",   32'(bus_err_o), 32'd1);
    check("ma_wbv",   32'(wb_valid_o), 32'd1);
    check("ma_wreg",  32'(wb_wreg_o), 32'd0);
    check("ma_stall", 32'(stallreq_o), 32'd0);
    tick();
    check("ma_err_pulse", 32'(bus_err_o), 32'd0);
`else
    do_load("ma_lw", OP_LW, 32'h102, 32'hCAFEF00D, 32'hCAFEF00D);
    do_store("ma_sh", OP_SH, 32'h101, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
